hamming_rx_controller: RTL and testbench
========================================

# hamming_rx_controller

Sequencing controller for the Hamming(7,4) UART receiver. It generates the receiver's oversample tick (`rx_ena`) and holds the receiver idle until the line is quiet. It edge-detects each received codeword, corrects single-bit errors, and buffers the decoded nibbles in a small FIFO behind a ready/valid port. It sits between the receiver and the downstream nibble consumer, and also exposes status counters.

## Interface
- `DIV`, default 13: system clocks per oversample tick (8 ticks per bit); must be ≥ 2.
- `DEPTH`, default 4: FIFO depth in nibbles; must be a power of two, ≥ 2.
- `SYNC_TICKS`, default 16: consecutive idle-high ticks required before the receiver is released.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run request.
- `clr` in 1: synchronous clear of `corr_count` and `overflow`.
- `rx` in 1: serial line, monitored only; idle level is 1.
- `rx_valid` in 1: receiver `valid_out`.
- `rx_data` in 7: receiver `data_out`, the codeword.
- `rx_ena` out 1: one-clock tick to the receiver `ena`.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head entry.
- `out_data` out 4: head nibble {d4,d3,d2,d1}.
- `out_corrected` out 1: the head entry had a bit corrected.
- `overflow` out 1: sticky; a nibble was dropped because the FIFO was full.
- `corr_count` out 8: saturating count of corrected codewords.
- `state` out 2: OFF=0, SYNC=1, RUN=2, for debug.

## Operation
- **Prescaler:** counts 0..DIV-1 while `state` is not OFF. The terminal count produces an internal tick, and the counter restarts at 0 on entry to SYNC.
- **FSM:**
  - OFF → SYNC when `enable`=1.
  - SYNC: counts consecutive ticks with `rx`=1. Any tick with `rx`=0 resets the count to 0. Reaching SYNC_TICKS → RUN.
  - RUN: `rx_ena` equals the tick.
  - `enable`=0 in any state → OFF at the next edge.
- **`rx_ena`:** always 0 in OFF and SYNC, so the receiver cannot start mid-frame.
- **Edge detect:** `rx_valid` stays high for a full tick period. A codeword is taken only on a 0→1 transition, using a registered previous value. `rx_valid` is ignored outside RUN, but the previous value is still tracked.
- **Codeword layout:** cw[0]=p1, cw[1]=p2, cw[2]=d1, cw[3]=p4, cw[4]=d2, cw[5]=d3, cw[6]=d4.
- **Syndrome bits:**
  - s1 = cw0^cw2^cw4^cw6
  - s2 = cw1^cw2^cw5^cw6
  - s4 = cw3^cw4^cw5^cw6
- **Correction:** syndrome s = {s4,s2,s1}. If s≠0, flip cw[s-1] and set corrected=1. Nibble = {cw6,cw5,cw4,cw2} after correction.
- **FIFO push:** accepted when not full, or when full with a pop in the same cycle. Push while full without a pop drops the nibble and sets `overflow`.
- **FIFO pop:** happens on `out_valid`&&`out_ready`.
- **Pointers:** log2(DEPTH)+1 bits, wrap naturally.
- **`corr_count`:** increments on each accepted or dropped corrected codeword, saturates at 255.
- **`clr`:** zeroes `corr_count` and `overflow`. It has priority over a same-cycle increment or set.
- **`enable` deasserted:** FIFO contents are retained and remain drainable. A codeword already in the decode stage completes its push.

## Timing
- **Reset values:**
  - `state`=OFF; `rx_ena`=0.
  - `out_valid`=0, `out_data`=0, `out_corrected`=0.
  - `overflow`=0, `corr_count`=0.
  - FIFO empty; prescaler 0; previous `rx_valid`=0.
- **Reset mid-frame:** discards everything immediately.
- **`rx_ena`:** high exactly one clock every DIV clocks in RUN. The first tick comes DIV clocks after SYNC entry.
- **Decode latency:**
  - A rising edge of `rx_valid` sampled at edge N latches the codeword.
  - Decode and FIFO write happen at edge N+1.
  - With the FIFO empty, `out_valid`=1 from edge N+1.
- **Output path:** `out_data`/`out_corrected` are the registered FIFO head, stable while `out_valid`=1 and `out_ready`=0.
- **SYNC to RUN:** the transition occurs at the edge of the SYNC_TICKS-th qualifying tick.

## Structure
- **Shared package `hamming_rx_pkg`:**
  - State encoding, with OFF/SYNC/RUN values.
  - Codeword bit-position constants.
  - Oversample factor 8.
  - Function `hamming74_correct`, which returns {corrected, nibble}.
- **Sub-module `rx_fifo`:** synchronous DEPTH×5 FIFO with push, pop, full, empty, and registered head.
- The FSM, prescaler, edge detect and counters live in the top module.

## Test plan
- **Clean frame:** `enable`=1 with `rx` held 1 for 16 ticks, then codeword 7'h55 → `out_data`=4'hB, `out_corrected`=0, `corr_count`=0. `out_valid` rises 1 clock after the `rx_valid` edge.
- **Single-bit error:** codeword 7'h45 (cw4 flipped) → `out_data`=4'hB, `out_corrected`=1, `corr_count`=1. Repeat for all 7 bit positions with the same nibble.
- **Overflow:** with `out_ready`=0, deliver DEPTH+1=5 codewords → 4 entries held, `overflow`=1. Then push and pop in the same cycle while full → no drop, `overflow` unchanged.
- **SYNC rejection:** `rx` pulses 0 on tick 10 of SYNC → count restarts, and RUN is entered 16 idle ticks later. `rx_ena`=0 throughout SYNC.
- **Long `rx_valid` pulse:** `rx_valid` held 1 for 13 clocks → exactly one FIFO entry.
- **Disable, clear and reset:** `enable`=0 with 2 entries queued → `rx_ena`=0 and both entries still drain. `clr` → `corr_count`=0 and `overflow`=0. `rst_n` pulsed low mid-frame → all outputs at their reset values.

Source files
------------

// File: rtl/hamming_rx_controller_pkg.sv
// Shared definitions for the Hamming(7,4) receive path: FSM encoding,
// codeword bit positions and the single-error-correcting decoder.
package hamming_rx_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } rx_state_t;

    localparam int CW_P1 = 0;
    localparam int CW_P2 = 1;
    localparam int CW_D1 = 2;
    localparam int CW_P4 = 3;
    localparam int CW_D2 = 4;
    localparam int CW_D3 = 5;
    localparam int CW_D4 = 6;

    localparam int OVERSAMPLE = 8;

    // Returns {corrected, d4, d3, d2, d1}; the syndrome value is the 1-based flipped position
    function automatic logic [4:0] hamming74_correct(input logic [6:0] cw);
        logic [2:0] syn;
        logic [6:0] fix;
        syn[0] = cw[CW_P1] ^ cw[CW_D1] ^ cw[CW_D2] ^ cw[CW_D4];
        syn[1] = cw[CW_P2] ^ cw[CW_D1] ^ cw[CW_D3] ^ cw[CW_D4];
        syn[2] = cw[CW_P4] ^ cw[CW_D2] ^ cw[CW_D3] ^ cw[CW_D4];
        fix = cw;
        case (syn)
            3'd1:    fix[CW_P1] = ~cw[CW_P1];
            3'd2:    fix[CW_P2] = ~cw[CW_P2];
            3'd3:    fix[CW_D1] = ~cw[CW_D1];
            3'd4:    fix[CW_P4] = ~cw[CW_P4];
            3'd5:    fix[CW_D2] = ~cw[CW_D2];
            3'd6:    fix[CW_D3] = ~cw[CW_D3];
            3'd7:    fix[CW_D4] = ~cw[CW_D4];
            default: fix = cw;
        endcase
        return {(syn != 3'd0), fix[CW_D4], fix[CW_D3], fix[CW_D2], fix[CW_D1]};
    endfunction

endpackage

// File: rtl/hamming_rx_controller_if.sv
// Receiver-side and consumer-side handshake bundle of the Hamming RX controller.
interface hamming_rx_controller_if;
    logic       rx_valid;
    logic [6:0] rx_data;
    logic       rx_ena;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_corrected;

    modport master (
        output rx_valid, rx_data, out_ready,
        input  rx_ena, out_valid, out_data, out_corrected
    );

    modport slave (
        input  rx_valid, rx_data, out_ready,
        output rx_ena, out_valid, out_data, out_corrected
    );
endinterface

// File: rtl/hamming_rx_controller_rx_fifo.sv
// Small synchronous FIFO with a registered head entry, so the consumer sees
// flop outputs and a write into an empty FIFO is visible the very next cycle.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_next_s, rd_next_s;
    logic             full_r, valid_r, full_next_s, valid_next_s;
    logic             push_ok_s, pop_ok_s;
    logic [WIDTH-1:0] head_r, head_next_s;

    // Qualify push/pop and look ahead to the entry that will sit at the head
    always_comb begin
        pop_ok_s     = pop && valid_r;
        push_ok_s    = push && (!full_r || pop_ok_s);
        rd_next_s    = rd_ptr_r + {{AW{1'b0}}, pop_ok_s};
        wr_next_s    = wr_ptr_r + {{AW{1'b0}}, push_ok_s};
        valid_next_s = (rd_next_s != wr_next_s);
        full_next_s  = ((wr_next_s - rd_next_s) == DEPTH_P);
        if (!valid_next_s) begin
            head_next_s = head_r;
        end else if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_next_s[AW-1:0]];
        end
    end

    // Storage array write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '{default: '0};
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointers, status flags and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
            head_r   <= '0;
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            full_r   <= full_next_s;
            valid_r  <= valid_next_s;
            head_r   <= head_next_s;
        end
    end

    assign full  = full_r;
    assign empty = !valid_r;
    assign head  = head_r;
endmodule

// File: rtl/hamming_rx_controller.sv
// Sequencing controller for the Hamming(7,4) UART receiver: oversample tick,
// line-idle synchronisation, codeword capture/correction and nibble buffering.
module hamming_rx_controller
    import hamming_rx_pkg::*;
#(
    parameter int DIV        = 13,
    parameter int DEPTH      = 4,
    parameter int SYNC_TICKS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clr,
    input  logic                    rx,
    hamming_rx_controller_if.slave  bus,
    output logic                    overflow,
    output logic [7:0]              corr_count,
    output logic [1:0]              state
);
    localparam int CW = $clog2(DIV);
    localparam int SW = $clog2(SYNC_TICKS + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_TICKS - 1);

    rx_state_t     state_r, state_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic [SW-1:0] sync_r, sync_next_s;
    logic          tick_r, rx_ena_r;
    logic          rx_valid_prev_r, take_s, cw_vld_r;
    logic [6:0]    cw_r;
    logic [4:0]    dec_s, head_s;
    logic          fifo_full_s, fifo_empty_s, pop_s, drop_s;
    logic [7:0]    corr_count_r;
    logic          overflow_r;

    // Next-state logic; the idle counter only advances on oversample ticks
    always_comb begin
        state_next_s = state_r;
        sync_next_s  = sync_r;
        if (!enable) begin
            state_next_s = ST_OFF;
            sync_next_s  = '0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_next_s = ST_SYNC;
                    sync_next_s  = '0;
                end
                ST_SYNC: begin
                    if (tick_r && rx && (sync_r == SYNC_LAST)) begin
                        state_next_s = ST_RUN;
                        sync_next_s  = '0;
                    end else if (tick_r && rx) begin
                        sync_next_s = sync_r + SW'(1);
                    end else if (tick_r) begin
                        sync_next_s = '0;
                    end else begin
                        sync_next_s = sync_r;
                    end
                end
                ST_RUN:  state_next_s = ST_RUN;
                default: state_next_s = ST_OFF;
            endcase
        end
    end

    // Prescaler restarts from zero whenever leaving or sitting in OFF
    always_comb begin
        if ((state_r == ST_OFF) || (state_next_s == ST_OFF)) begin
            cnt_next_s = '0;
        end else if (cnt_r == DIV_LAST) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CW'(1);
        end
    end

    // FSM, prescaler and tick registers; rx_ena is a lookahead of the RUN tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_OFF;
            sync_r   <= '0;
            cnt_r    <= '0;
            tick_r   <= 1'b0;
            rx_ena_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            sync_r   <= sync_next_s;
            cnt_r    <= cnt_next_s;
            tick_r   <= (cnt_next_s == DIV_LAST);
            rx_ena_r <= (state_next_s == ST_RUN) && (cnt_next_s == DIV_LAST);
        end
    end

    assign take_s = bus.rx_valid && !rx_valid_prev_r && (state_r == ST_RUN);

    // Rising-edge capture of the codeword; the decode stage finishes even after disable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_prev_r <= 1'b0;
            cw_vld_r        <= 1'b0;
            cw_r            <= 7'd0;
        end else begin
            rx_valid_prev_r <= bus.rx_valid;
            cw_vld_r        <= take_s;
            if (take_s) begin
                cw_r <= bus.rx_data;
            end
        end
    end

    assign dec_s  = hamming74_correct(cw_r);
    assign pop_s  = !fifo_empty_s && bus.out_ready;
    assign drop_s = cw_vld_r && fifo_full_s && !pop_s;

    rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cw_vld_r),
        .din   (dec_s),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s)
    );

    // Status counters; clear wins over a same-cycle increment or overflow set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count_r <= 8'd0;
            overflow_r   <= 1'b0;
        end else if (clr) begin
            corr_count_r <= 8'd0;
            overflow_r   <= 1'b0;
        end else begin
            if (cw_vld_r && dec_s[4] && (corr_count_r != 8'hFF)) begin
                corr_count_r <= corr_count_r + 8'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus.rx_ena        = rx_ena_r;
    assign bus.out_valid     = !fifo_empty_s;
    assign bus.out_data      = head_s[3:0];
    assign bus.out_corrected = head_s[4];
    assign overflow          = overflow_r;
    assign corr_count        = corr_count_r;
    assign state             = state_r;
endmodule

// File: tb/tb_hamming_rx_controller.sv
// Scoreboard bench for hamming_rx_controller: expected {corrected, nibble} entries
// are queued as codewords are driven and compared as the consumer pops them.
module tb_hamming_rx_controller;
    import hamming_rx_pkg::*;

    localparam int DIV        = 13;
    localparam int DEPTH      = 4;
    localparam int SYNC_TICKS = 16;
    localparam int BIT_CLKS   = DIV * OVERSAMPLE;

    logic       clk, rst_n, enable, clr, rx;
    logic       overflow;
    logic [7:0] corr_count;
    logic [1:0] state;

    hamming_rx_controller_if bus();

    hamming_rx_controller #(
        .DIV        (DIV),
        .DEPTH      (DEPTH),
        .SYNC_TICKS (SYNC_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clr        (clr),
        .rx         (rx),
        .bus        (bus),
        .overflow   (overflow),
        .corr_count (corr_count),
        .state      (state)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [4:0] sb_q[$];
    logic [4:0] mon_exp;
    logic [7:0] exp_cc   = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder built from the parity equations: p1 covers d1,d2,d4; p2 d1,d3,d4; p4 d2,d3,d4
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Consumer-side scoreboard: every accepted head must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got %h, required no entry", {bus.out_corrected, bus.out_data});
            end else begin
                mon_exp = sb_q.pop_front();
                if ({bus.out_corrected, bus.out_data} !== mon_exp) begin
                    failures++;
                    $display("FAIL pop_data: got %h, required %h", {bus.out_corrected, bus.out_data}, mon_exp);
                end
            end
        end
    end

    task automatic send_cw(input logic [6:0] cw, input logic [4:0] exp, input bit taken,
                           input bit accept, input int hold, input bit pop_at_push);
        bus.rx_valid = 1'b1;
        bus.rx_data  = cw;
        if (accept) sb_q.push_back(exp);
        if (taken && exp[4] && exp_cc != 8'd255) exp_cc++;
        @(posedge clk); #1;
        if (pop_at_push) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
        for (int i = (pop_at_push ? 2 : 1); i < hold; i++) begin
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 4 * DEPTH + 8 && sb_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d, required 0", state); end
        checks++; if (bus.rx_ena !== 1'b0) begin failures++; $display("FAIL reset_rx_ena: got %b, required 0", bus.rx_ena); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if ({bus.out_corrected, bus.out_data} !== 5'h00) begin failures++; $display("FAIL reset_head: got %h, required 00", {bus.out_corrected, bus.out_data}); end
        checks++; if ({overflow, corr_count} !== 9'h000) begin failures++; $display("FAIL reset_status: got %h, required 000", {overflow, corr_count}); end
    endtask

    task automatic test_sync(input int reject_tick);
        int   n;
        int   exp_n;
        logic seen_ena;
        exp_n = ((reject_tick > 0) ? reject_tick + SYNC_TICKS : SYNC_TICKS) * DIV;
        enable = 1'b0;
        rx     = 1'b1;
        @(posedge clk); #1;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL sync_off: got %0d, required 0", state); end
        enable = 1'b1;
        @(posedge clk); #1;
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL sync_entry: got %0d, required 1", state); end
        n        = 0;
        seen_ena = 1'b0;
        while (state === 2'd1 && n < exp_n + 4 * DIV) begin
            rx = (reject_tick > 0 && n == reject_tick * DIV - 1) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            n++;
            if (state === 2'd1 && bus.rx_ena === 1'b1) seen_ena = 1'b1;
        end
        rx = 1'b1;
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL sync_run: got %0d, required 2", state); end
        checks++; if (n !== exp_n) begin failures++; $display("FAIL sync_len: got %0d clocks, required %0d", n, exp_n); end
        checks++; if (seen_ena !== 1'b0) begin failures++; $display("FAIL sync_rx_ena: got %b, required 0", seen_ena); end
    endtask

    task automatic test_rx_ena_period();
        int n;
        n = 0;
        while (bus.rx_ena !== 1'b1 && n < 2 * DIV) begin @(posedge clk); #1; n++; end
        checks++; if (bus.rx_ena !== 1'b1) begin failures++; $display("FAIL ena_seen: got %b, required 1", bus.rx_ena); end
        @(posedge clk); #1;
        checks++; if (bus.rx_ena !== 1'b0) begin failures++; $display("FAIL ena_width: got %b, required 0", bus.rx_ena); end
        n = 1;
        while (bus.rx_ena !== 1'b1 && n < 2 * DIV) begin @(posedge clk); #1; n++; end
        checks++; if (n !== DIV) begin failures++; $display("FAIL ena_period: got %0d, required %0d", n, DIV); end
    endtask

    task automatic test_clean_frame();
        logic [3:0] nibs [4] = '{4'h0, 4'h5, 4'hA, 4'hF};
        bus.out_ready = 1'b0;
        bus.rx_valid  = 1'b1;
        bus.rx_data   = 7'h55;
        sb_q.push_back(5'h0B);
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL clean_valid_early: got %b, required 0", bus.out_valid); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL clean_valid_latency: got %b, required 1", bus.out_valid); end
        checks++; if ({bus.out_corrected, bus.out_data} !== 5'h0B) begin failures++; $display("FAIL clean_head: got %h, required 0b", {bus.out_corrected, bus.out_data}); end
        checks++; if (corr_count !== 8'd0) begin failures++; $display("FAIL clean_corr_count: got %0d, required 0", corr_count); end
        for (int i = 2; i < DIV; i++) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
        drain();
        for (int i = 0; i < 4; i++) send_cw(enc(nibs[i]), {1'b0, nibs[i]}, 1'b1, 1'b1, DIV, 1'b0);
        drain();
        checks++; if (sb_q.size() !== 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL clean_drain: got %0d left valid=%b, required 0", sb_q.size(), bus.out_valid); end
    endtask

    task automatic test_single_bit_errors();
        logic [6:0] one = 7'd1;
        for (int i = 0; i < 7; i++) begin
            send_cw(7'h55 ^ (one << i), 5'h1B, 1'b1, 1'b1, DIV, 1'b0);
            checks++; if ({bus.out_valid, bus.out_corrected, bus.out_data} !== 6'h3B) begin failures++; $display("FAIL sbe_head bit %0d: got %h, required 3b", i, {bus.out_valid, bus.out_corrected, bus.out_data}); end
            checks++; if (corr_count !== exp_cc) begin failures++; $display("FAIL sbe_corr_count bit %0d: got %0d, required %0d", i, corr_count, exp_cc); end
            drain();
        end
        checks++; if (sb_q.size() !== 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL sbe_drain: got %0d left valid=%b, required 0", sb_q.size(), bus.out_valid); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= DEPTH; k++) send_cw(enc(4'(k)), {1'b0, 4'(k)}, 1'b1, 1'b1, DIV, 1'b0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b, required 0", overflow); end
        send_cw(enc(4'h5) ^ 7'h04, 5'h15, 1'b1, 1'b0, DIV, 1'b0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        checks++; if (corr_count !== exp_cc) begin failures++; $display("FAIL ovf_corr_count: got %0d, required %0d", corr_count, exp_cc); end
        send_cw(enc(4'h6), 5'h06, 1'b1, 1'b1, DIV, 1'b1);
        checks++; if ({bus.out_valid, overflow} !== 2'b11) begin failures++; $display("FAIL ovf_push_pop: got %b, required 11", {bus.out_valid, overflow}); end
        drain();
        checks++; if (sb_q.size() !== 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain: got %0d left valid=%b, required 0", sb_q.size(), bus.out_valid); end
    endtask

    task automatic test_clear();
        clr = 1'b1;
        @(posedge clk); #1;
        clr    = 1'b0;
        exp_cc = 8'd0;
        checks++; if ({overflow, corr_count} !== 9'h000) begin failures++; $display("FAIL clr_status: got %h, required 000", {overflow, corr_count}); end
        clr = 1'b1;
        send_cw(enc(4'h9) ^ 7'h01, 5'h19, 1'b1, 1'b1, DIV, 1'b0);
        clr    = 1'b0;
        exp_cc = 8'd0;
        checks++; if (corr_count !== exp_cc) begin failures++; $display("FAIL clr_priority: got %0d, required 0", corr_count); end
        drain();
    endtask

    task automatic test_long_pulse();
        send_cw(enc(4'h9), 5'h09, 1'b1, 1'b1, 13, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (sb_q.size() !== 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL long_pulse_entries: got %0d left valid=%b, required 0", sb_q.size(), bus.out_valid); end
    endtask

    task automatic test_disable();
        logic seen_ena;
        send_cw(enc(4'hC), 5'h0C, 1'b1, 1'b1, DIV, 1'b0);
        send_cw(enc(4'h3) ^ 7'h40, 5'h13, 1'b1, 1'b1, DIV, 1'b0);
        enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL dis_state: got %0d, required 0", state); end
        seen_ena = 1'b0;
        for (int i = 0; i < BIT_CLKS; i++) begin
            @(posedge clk); #1;
            if (bus.rx_ena === 1'b1) seen_ena = 1'b1;
        end
        checks++; if (seen_ena !== 1'b0) begin failures++; $display("FAIL dis_rx_ena: got %b, required 0", seen_ena); end
        send_cw(enc(4'h7), 5'h07, 1'b0, 1'b0, DIV, 1'b0);
        checks++; if (corr_count !== exp_cc) begin failures++; $display("FAIL dis_corr_count: got %0d, required %0d", corr_count, exp_cc); end
        drain();
        checks++; if (sb_q.size() !== 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL dis_drain: got %0d left valid=%b, required 0", sb_q.size(), bus.out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        test_sync(0);
        send_cw(enc(4'hE) ^ 7'h08, 5'h1E, 1'b1, 1'b1, DIV, 1'b0);
        checks++; if (corr_count !== exp_cc) begin failures++; $display("FAIL rst_pre_corr_count: got %0d, required %0d", corr_count, exp_cc); end
        bus.rx_valid = 1'b1;
        bus.rx_data  = enc(4'h2);
        @(posedge clk); #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        #2;
        checks++; if (state !== 2'd0 || bus.rx_ena !== 1'b0) begin failures++; $display("FAIL rst_fsm: got %0d/%b, required 0/0", state, bus.rx_ena); end
        checks++; if ({bus.out_valid, bus.out_corrected, bus.out_data} !== 6'h00) begin failures++; $display("FAIL rst_out: got %h, required 00", {bus.out_valid, bus.out_corrected, bus.out_data}); end
        checks++; if ({overflow, corr_count} !== 9'h000) begin failures++; $display("FAIL rst_status: got %h, required 000", {overflow, corr_count}); end
        sb_q.delete();
        exp_cc       = 8'd0;
        bus.rx_valid = 1'b0;
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_after: got %b, required 0", bus.out_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        clr           = 1'b0;
        rx            = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 7'd0;
        bus.out_ready = 1'b0;
        #22;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_sync(0);
        test_rx_ena_period();
        test_clean_frame();
        test_single_bit_errors();
        test_overflow();
        test_clear();
        test_long_pulse();
        test_sync(10);
        test_disable();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
